midi_rx_parser: RTL and testbench

MIDI_RX_PARSER -- requirements
Module: midi_rx_parser

---
 rtl/midi_rx_parser.sv | 212 +++++++++++++++++++++
 tb/tb_midi_rx_parser.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/midi_rx_parser.sv
// MIDI receiver: synchronizes the serial line, deframes 8N1 bytes and
// assembles channel voice messages (with running status) for the host.
module midi_rx_parser #(
  parameter int BAUD_DIV    = 3200,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       msg_valid,
  output logic [7:0] status,
  output logic [7:0] data1,
  output logic [7:0] data2,
  output logic [1:0] bytes_cnt,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Synchronizer and edge-qualification state
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   prev_hi_q, prev_hi_d;
  logic                   rx_s;

  // Byte receiver state
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             ferr_wait_q, ferr_wait_d;
  logic             frame_err_q, frame_err_d;
  logic             byte_vld;

  // Message parser state
  logic [7:0] rs_q, rs_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] d1p_q, d1p_d;
  logic [7:0] status_q, status_d;
  logic [7:0] data1_q, data1_d;
  logic [7:0] data2_q, data2_d;
  logic [1:0] bytes_cnt_q, bytes_cnt_d;
  logic       msg_valid_q, msg_valid_d;
  logic       two_data;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Shift rx through the synchronizer; fill_q marks when the chain holds real
  // line samples rather than reset values, so a line held low through reset
  // is never mistaken for a start bit.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], rx};
    fill_d    = {fill_q[SYNC_STAGES-2:0], 1'b1};
    prev_hi_d = fill_q[SYNC_STAGES-1] & rx_s;
  end

  // Byte FSM: start detection, mid-bit sampling, stop-bit check
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    ferr_wait_d = ferr_wait_q;
    frame_err_d = 1'b0;
    byte_vld    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (prev_hi_q && !rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          bit_d = 3'd0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (ferr_wait_q) begin
          // Broken frame: hold here until the line returns to idle
          cnt_d = '0;
          if (rx_s) begin
            ferr_wait_d = 1'b0;
            state_d     = S_IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_vld = 1'b1;
            state_d  = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            ferr_wait_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Parser: running status, data collection and message completion
  always_comb begin
    rs_d        = rs_q;
    idx_d       = idx_q;
    d1p_d       = d1p_q;
    status_d    = status_q;
    data1_d     = data1_q;
    data2_d     = data2_q;
    bytes_cnt_d = bytes_cnt_q;
    msg_valid_d = 1'b0;
    two_data    = !((rs_q[7:4] == 4'hC) || (rs_q[7:4] == 4'hD));
    if (byte_vld) begin
      if (shift_q[7]) begin
        if (shift_q >= 8'hF8) begin
          // Real-time byte: transparent to the message in progress
        end else if (shift_q >= 8'hF0) begin
          rs_d  = 8'h00;
          idx_d = 2'd0;
        end else begin
          rs_d  = shift_q;
          idx_d = 2'd0;
        end
      end else if (rs_q != 8'h00) begin
        if (idx_q == 2'd0 && !two_data) begin
          status_d    = rs_q;
          data1_d     = shift_q;
          data2_d     = 8'h00;
          bytes_cnt_d = 2'd2;
          msg_valid_d = 1'b1;
        end else if (idx_q == 2'd0) begin
          d1p_d = shift_q;
          idx_d = 2'd1;
        end else begin
          status_d    = rs_q;
          data1_d     = d1p_q;
          data2_d     = shift_q;
          bytes_cnt_d = 2'd3;
          msg_valid_d = 1'b1;
          idx_d       = 2'd0;
        end
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '1;
      fill_q      <= '0;
      prev_hi_q   <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      ferr_wait_q <= 1'b0;
      frame_err_q <= 1'b0;
      rs_q        <= 8'h00;
      idx_q       <= 2'd0;
      d1p_q       <= 8'h00;
      status_q    <= 8'h00;
      data1_q     <= 8'h00;
      data2_q     <= 8'h00;
      bytes_cnt_q <= 2'd0;
      msg_valid_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      fill_q      <= fill_d;
      prev_hi_q   <= prev_hi_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      ferr_wait_q <= ferr_wait_d;
      frame_err_q <= frame_err_d;
      rs_q        <= rs_d;
      idx_q       <= idx_d;
      d1p_q       <= d1p_d;
      status_q    <= status_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      bytes_cnt_q <= bytes_cnt_d;
      msg_valid_q <= msg_valid_d;
    end
  end

  assign msg_valid = msg_valid_q;
  assign status    = status_q;
  assign data1     = data1_q;
  assign data2     = data2_q;
  assign bytes_cnt = bytes_cnt_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_midi_rx_parser.sv
// Bench for midi_rx_parser: serial byte driver, scoreboard of expected
// messages, and a negedge monitor that pops and compares each msg_valid.
module tb_midi_rx_parser;
  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b0;
  logic       msg_valid;
  logic [7:0] status, data1, data2;
  logic [1:0] bytes_cnt;
  logic       frame_err, busy;

  midi_rx_parser #(.BAUD_DIV(BD), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rx(rx), .msg_valid(msg_valid), .status(status),
    .data1(data1), .data2(data2), .bytes_cnt(bytes_cnt),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] st;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [1:0] n;
  } msg_t;

  msg_t exp_q[$];
  msg_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   fe_cnt   = 0;
  int   busy_cnt = 0;
  int   msg_cnt  = 0;
  int   fe_base, busy_base, msg_base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2,
                      input logic [1:0] n);
    msg_t m;
    m.st = st; m.d1 = d1; m.d2 = d2; m.n = n;
    exp_q.push_back(m);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BD) @(negedge clk);
    end
    rx = stop;
    repeat (BD) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_msg_valid"}, msg_valid, 0);
    check({pfx, "_frame_err"}, frame_err, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_status"}, status, 0);
    check({pfx, "_data1"}, data1, 0);
    check({pfx, "_data2"}, data2, 0);
    check({pfx, "_bytes_cnt"}, bytes_cnt, 0);
  endtask

  // Monitor: compare every delivered message against the scoreboard
  always @(negedge clk) begin
    if (msg_valid) begin
      msg_cnt++;
      check("msg_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("status", status, mon_e.st);
        check("data1", data1, mon_e.d1);
        check("data2", data2, mon_e.d2);
        check("bytes_cnt", bytes_cnt, mon_e.n);
      end
    end
    if (frame_err) fe_cnt++;
    if (busy) busy_cnt++;
  end

  initial begin
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("rst");

    // Line held low across reset release must not start a frame
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("no_start_low_after_rst", busy, 0);
    idle(3 * BD);

    // Three-byte control change
    fe_base = fe_cnt;
    push(8'hB0, 8'h2E, 8'h7F, 2'd3);
    send_byte(8'hB0, 1'b1);
    send_byte(8'h2E, 1'b1);
    send_byte(8'h7F, 1'b1);
    idle(2 * BD);
    check("t1_pending", exp_q.size(), 0);
    check("t1_frame_err", fe_cnt - fe_base, 0);
    check("t1_hold_status", status, 8'hB0);
    check("t1_hold_data2", data2, 8'h7F);
    check("t1_pulse_low", msg_valid, 0);

    // Program change, then a second one under running status
    send_byte(8'hC0, 1'b1);
    push(8'hC0, 8'h42, 8'h00, 2'd2);
    send_byte(8'h42, 1'b1);
    push(8'hC0, 8'h43, 8'h00, 2'd2);
    send_byte(8'h43, 1'b1);
    idle(2 * BD);
    check("t2_pending", exp_q.size(), 0);

    // Note-on with a timing clock byte in the middle
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'hF8, 1'b1);
    push(8'h90, 8'h3C, 8'h64, 2'd3);
    send_byte(8'h64, 1'b1);
    idle(2 * BD);
    check("t3_pending", exp_q.size(), 0);

    // Framing error, then a clean message
    fe_base = fe_cnt;
    send_byte(8'hB0, 1'b0);
    idle(BD);
    check("t4_frame_err_once", fe_cnt - fe_base, 1);
    send_byte(8'hB0, 1'b1);
    send_byte(8'h01, 1'b1);
    push(8'hB0, 8'h01, 8'h02, 2'd3);
    send_byte(8'h02, 1'b1);
    idle(2 * BD);
    check("t4_pending", exp_q.size(), 0);
    check("t4_frame_err_total", fe_cnt - fe_base, 1);

    // Short glitch, then system common clears running status
    busy_base = busy_cnt;
    msg_base  = msg_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(2 * BD);
    check("t5_glitch_busy", (busy_cnt - busy_base) > 0, 1);
    check("t5_glitch_idle", busy, 0);
    send_byte(8'hF0, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h20, 1'b1);
    idle(2 * BD);
    check("t5_no_msg", msg_cnt - msg_base, 0);

    // Reset in the middle of data bit 4 of 0xB0 with a partial message open
    send_byte(8'h90, 1'b1);
    send_byte(8'h11, 1'b1);
    rx = 1'b0;
    repeat (5 * BD) @(negedge clk);
    rx = 1'b1;
    repeat (BD / 2) @(negedge clk);
    check("t6_busy_mid_byte", busy, 1);
    rst = 1'b1;
    #1;
    check_zero_outputs("t6_rst");
    @(negedge clk);
    rst = 1'b0;
    msg_base = msg_cnt;
    idle(3 * BD);
    send_byte(8'h05, 1'b1);
    send_byte(8'h06, 1'b1);
    idle(2 * BD);
    check("t6_no_msg", msg_cnt - msg_base, 0);
    check("t6_status_zero", status, 0);
    check("final_pending", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
